// File: rtl/cbb_row_accumulator_pkg.sv
// Shared constants and FSM encoding for the IMU receive-side row accumulator.
// The dispatcher side uses the same state encoding.
package cbb_row_accumulator_pkg;

  localparam int LANE_W = 32;
  localparam int LANES  = 4;
  localparam int DATA_W = LANES * LANE_W;
  localparam int NNZ_W  = 4;
  localparam int ROW_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } acc_state_t;

endpackage

// File: rtl/cbb_row_accumulator_if.sv
// Command, partial-product and finished-row channels of the row accumulator.
// master = command/IMU/output-buffer side, slave = the accumulator itself.
interface cbb_row_accumulator_if;
  import cbb_row_accumulator_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ROW_W-1:0]  cmd_row;
  logic [NNZ_W-1:0]  cmd_nnz;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ROW_W-1:0]  out_row;
  logic [DATA_W-1:0] out_data;
  logic              err_stray;

  modport master (
    output cmd_valid, cmd_row, cmd_nnz, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_valid, out_row, out_data, err_stray
  );

  modport slave (
    input  cmd_valid, cmd_row, cmd_nnz, in_valid, in_data, out_ready,
    output cmd_ready, in_ready, out_valid, out_row, out_data, err_stray
  );

endinterface

// File: rtl/cbb_row_accumulator_lane_adder.sv
// One accumulator lane: plain wrap-around add, carries never leave the lane.
module cbb_row_accumulator_lane_adder
  import cbb_row_accumulator_pkg::*;
#(
  parameter int WIDTH = LANE_W
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum
);

  assign o_sum = i_a + i_b;

endmodule

// File: rtl/cbb_row_accumulator.sv
// Row accumulator: takes one command per output row, sums cmd_nnz partial
// product beats lane-wise, then holds the finished row until the output
// buffer takes it.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | waiting for a row command (cmd_ready=1)
//   ST_ACCUM | taking partial-product beats until remaining hits zero
//   ST_DRAIN | finished row on out_*, held until out_ready
module cbb_row_accumulator
  import cbb_row_accumulator_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  cbb_row_accumulator_if.slave  bus
);

  acc_state_t        r_state;
  acc_state_t        w_state_nxt;
  logic              r_cmd_ready;
  logic              r_err_stray;
  logic [ROW_W-1:0]  r_row;
  logic [NNZ_W-1:0]  r_remaining;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_sum;
  logic              w_cmd_take;
  logic              w_beat_take;

  // r_cmd_ready is only set while the state register holds ST_IDLE, and stays
  // low for the first cycle after reset release, so it doubles as the IDLE
  // acceptance qualifier.
  assign w_cmd_take  = r_cmd_ready && bus.cmd_valid;
  assign w_beat_take = (r_state == ST_ACCUM) && bus.in_valid;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    cbb_row_accumulator_lane_adder #(.WIDTH(LANE_W)) u_lane_adder (
      .i_a   (r_acc[g*LANE_W +: LANE_W]),
      .i_b   (bus.in_data[g*LANE_W +: LANE_W]),
      .o_sum (w_sum[g*LANE_W +: LANE_W])
    );
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_take) begin
          w_state_nxt = (bus.cmd_nnz == '0) ? ST_DRAIN : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (w_beat_take && (r_remaining == NNZ_W'(1))) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered cmd_ready (held low while in reset).
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
    end
  end

  // Row latch, beat counter, lane accumulators and stray-beat flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_row       <= '0;
      r_remaining <= '0;
      r_acc       <= '0;
      r_err_stray <= 1'b0;
    end else begin
      r_err_stray <= bus.in_valid && (r_state != ST_ACCUM);
      if (w_cmd_take) begin
        r_row       <= bus.cmd_row;
        r_remaining <= bus.cmd_nnz;
        r_acc       <= '0;
      end else if (w_beat_take) begin
        r_acc       <= w_sum;
        r_remaining <= r_remaining - NNZ_W'(1);
      end
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.in_ready  = (r_state == ST_ACCUM);
  assign bus.out_valid = (r_state == ST_DRAIN);
  assign bus.out_row   = r_row;
  assign bus.out_data  = r_acc;
  assign bus.err_stray = r_err_stray;

endmodule

// File: tb/tb_cbb_row_accumulator.sv
// Testbench for cbb_row_accumulator: directed scenarios plus random rows,
// expected sums from a lane-wise modulo-2^32 reference model.
module tb_cbb_row_accumulator;
  import cbb_row_accumulator_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [DATA_W-1:0] beat_q [0:15];

  cbb_row_accumulator_if bus ();

  cbb_row_accumulator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: each lane is the plain sum of its lane values, reduced mod 2^32.
  function automatic logic [DATA_W-1:0] ref_sum(input int n);
    logic [DATA_W-1:0] res;
    longint unsigned   s;
    logic [DATA_W-1:0] b;
    res = '0;
    for (int lane = 0; lane < LANES; lane++) begin
      s = 0;
      for (int k = 0; k < n; k++) begin
        b = beat_q[k];
        s = s + longint'(b[lane*LANE_W +: LANE_W]);
      end
      s = s % 64'h1_0000_0000;
      res[lane*LANE_W +: LANE_W] = s[31:0];
    end
    return res;
  endfunction

  // Drives one complete row (command, beats with gaps, backpressured drain).
  task automatic drive_row(input logic [ROW_W-1:0] row, input int nnz,
                           input int gap_min, input int gap_max,
                           input int bp_min, input int bp_max, input string tag);
    logic [DATA_W-1:0] exp_d;
    int waited;
    int gaps;
    int bp;
    exp_d = ref_sum(nnz);
    waited = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s cmd_ready before command: got %b want 1", tag, bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_row   = row;
    bus.cmd_nnz   = NNZ_W'(nnz);
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_row   = ROW_W'($urandom);
    bus.cmd_nnz   = NNZ_W'($urandom);
    for (int b = 0; b < nnz; b++) begin
      gaps = $urandom_range(gap_max, gap_min);
      for (int g = 0; g < gaps; g++) begin
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s gap beat%0d: in_ready=%b out_valid=%b want 1/0",
                   tag, b, bus.in_ready, bus.out_valid);
        end
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = beat_q[b];
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s in_ready beat%0d: got %b want 1", tag, b, bus.in_ready);
      end
      tick();
      bus.in_valid = 1'b0;
      bus.in_data  = rnd_data();
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s out_valid timing: out_valid=%b in_ready=%b want 1/0",
               tag, bus.out_valid, bus.in_ready);
    end
    checks++;
    if (bus.out_row !== row) begin
      errors++;
      $display("FAIL %s out_row: got %0d want %0d", tag, bus.out_row, row);
    end
    checks++;
    if (bus.out_data !== exp_d) begin
      errors++;
      $display("FAIL %s out_data: got %h want %h", tag, bus.out_data, exp_d);
    end
    bp = $urandom_range(bp_max, bp_min);
    for (int k = 0; k < bp; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d || bus.out_row !== row) begin
        errors++;
        $display("FAIL %s hold cycle%0d: valid=%b data=%h row=%0d want 1/%h/%0d",
                 tag, k, bus.out_valid, bus.out_data, bus.out_row, exp_d, row);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after handshake: out_valid=%b cmd_ready=%b want 0/1",
               tag, bus.out_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if ({bus.cmd_ready, bus.in_ready, bus.out_valid, bus.err_stray} !== 4'b0000 ||
          bus.out_row !== '0 || bus.out_data !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: rdy=%b inrdy=%b ov=%b err=%b row=%0d data=%h want all 0",
                 k, bus.cmd_ready, bus.in_ready, bus.out_valid, bus.err_stray,
                 bus.out_row, bus.out_data);
      end
    end
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release cmd_ready: got %b want 1", bus.cmd_ready);
    end
    // Start a row and abort it with reset partway through.
    bus.cmd_valid = 1'b1;
    bus.cmd_row   = 4'd7;
    bus.cmd_nnz   = 4'd3;
    tick();
    bus.cmd_valid = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = {32'd9, 32'd8, 32'd7, 32'd6};
    tick();
    bus.in_valid  = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_accum in_ready: got %b want 1", bus.in_ready);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if ({bus.cmd_ready, bus.in_ready, bus.out_valid, bus.err_stray} !== 4'b0000 ||
          bus.out_row !== '0 || bus.out_data !== '0) begin
        errors++;
        $display("FAIL reset_mid cyc%0d: rdy=%b inrdy=%b ov=%b err=%b row=%0d data=%h want all 0",
                 k, bus.cmd_ready, bus.in_ready, bus.out_valid, bus.err_stray,
                 bus.out_row, bus.out_data);
      end
    end
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid release cmd_ready: got %b want 1", bus.cmd_ready);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_discard cyc%0d: out_valid=%b in_ready=%b want 0/0",
                 k, bus.out_valid, bus.in_ready);
      end
    end
    beat_q[0] = {32'd1, 32'd1, 32'd1, 32'd1};
    drive_row(4'd3, 1, 0, 0, 0, 0, "reset_after_row");
  endtask

  task automatic test_single_row();
    beat_q[0] = {32'd4, 32'd3, 32'd2, 32'd1};
    beat_q[1] = {32'd40, 32'd30, 32'd20, 32'd10};
    beat_q[2] = '0;
    drive_row(4'd5, 3, 0, 0, 0, 0, "single_row");
    checks++;
    if (ref_sum(3) !== {32'd44, 32'd33, 32'd22, 32'd11}) begin
      errors++;
      $display("FAIL single_row model: got %h want lanes 44/33/22/11", ref_sum(3));
    end
  endtask

  task automatic test_empty_row();
    drive_row(4'd2, 0, 0, 0, 0, 0, "empty_row");
  endtask

  task automatic test_wrap();
    logic [DATA_W-1:0] got;
    beat_q[0] = {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};
    beat_q[1] = {32'd0, 32'd0, 32'd0, 32'h0000_0002};
    drive_row(4'd9, 2, 0, 0, 3, 3, "wrap");
    beat_q[0] = {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};
    beat_q[1] = {32'd0, 32'd0, 32'd0, 32'h0000_0002};
    bus.cmd_valid = 1'b1;
    bus.cmd_row   = 4'd9;
    bus.cmd_nnz   = 4'd2;
    tick();
    bus.cmd_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = beat_q[b];
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    got = bus.out_data;
    checks++;
    if (got[31:0] !== 32'h0000_0001 || got[63:32] !== 32'h0) begin
      errors++;
      $display("FAIL wrap lanes: lane0=%h lane1=%h want 00000001/00000000", got[31:0], got[63:32]);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    beat_q[0] = {32'd100, 32'd200, 32'd300, 32'd400};
    beat_q[1] = {32'd5, 32'd6, 32'd7, 32'd8};
    drive_row(4'd11, 2, 3, 3, 5, 5, "backpressure");
    for (int k = 0; k < 2; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL backpressure single handshake cyc%0d: out_valid=%b cmd_ready=%b want 0/1",
                 k, bus.out_valid, bus.cmd_ready);
      end
    end
  endtask

  task automatic test_stray();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = {4{32'hAAAA_AAAA}};
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.err_stray !== 1'b1) begin
      errors++;
      $display("FAIL stray pulse: got %b want 1", bus.err_stray);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.err_stray !== 1'b0) begin
      errors++;
      $display("FAIL stray pulse width: got %b want 0", bus.err_stray);
    end
    beat_q[0] = {32'd1, 32'd2, 32'd3, 32'd4};
    beat_q[1] = {32'd10, 32'd10, 32'd10, 32'd10};
    drive_row(4'd1, 2, 0, 1, 0, 1, "stray_followup");
  endtask

  task automatic test_random_rows();
    int nnz;
    for (int r = 0; r < 10; r++) begin
      nnz = $urandom_range(15, 0);
      for (int b = 0; b < 16; b++) beat_q[b] = rnd_data();
      drive_row(ROW_W'($urandom), nnz, 0, 2, 0, 3, "random_row");
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      for (int b = 0; b < 16; b++) beat_q[b] = rnd_data();
      drive_row(ROW_W'(r + 12), r + 1, 0, 0, 0, 0, "back_to_back");
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_row   = '0;
    bus.cmd_nnz   = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    for (int b = 0; b < 16; b++) beat_q[b] = '0;
    test_reset();
    test_single_row();
    test_empty_row();
    test_wrap();
    test_backpressure();
    test_stray();
    test_back_to_back();
    test_random_rows();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cbb_row_accumulator.md
# cbb_row_accumulator

Receive side of the IMU datapath. Collects the per-nonzero partial products the IMUs emit (128-bit, 4×32-bit lanes), sums them lane-wise into one output row, and hands the finished row to the output buffer over a valid/ready handshake. One command per output row gives the row index and the number of partial products (NNZ from the NNZ/row predictor) to expect.

## Interface
- LANE_W, 32, width of one lane (fixed-point, unsigned).
- LANES, 4, lanes per beat; data width = LANES*LANE_W = 128.
- NNZ_W, 4, width of nonzero count per row (max 15).
- ROW_W, 4, width of row index.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  row command present.
- cmd_ready  out  1  accumulator can take a command.
- cmd_row  in  ROW_W  output row index.
- cmd_nnz  in  NNZ_W  partial-product beats to sum for this row.
- in_valid  in  1  IMU partial-product beat present (IMU CBB_valid).
- in_ready  out  1  beat accepted this cycle.
- in_data  in  LANES*LANE_W  partial product, lane i at bits [i*LANE_W +: LANE_W].
- out_valid  out  1  finished row present.
- out_ready  in  1  output buffer takes the row.
- out_row  out  ROW_W  row index of finished row.
- out_data  out  LANES*LANE_W  lane-wise sum.
- err_stray  out  1  one-cycle pulse: in_valid seen while not accumulating.

## Operation
- FSM states IDLE, ACCUM, DRAIN. Reset state IDLE.
- IDLE: cmd_ready=1, in_ready=0. On cmd_valid: latch cmd_row, load remaining=cmd_nnz, clear acc. cmd_nnz≠0 → ACCUM; cmd_nnz=0 → DRAIN with acc=0.
- ACCUM: cmd_ready=0, in_ready=1. Each in_valid beat: acc[i] += in_data lane i, remaining -= 1. Beat with remaining=1 → DRAIN. Cycles without in_valid hold state.
- DRAIN: out_valid=1, out_data=acc, out_row=latched row; both stable until out_ready. On out_valid&&out_ready → IDLE.
- Arithmetic: each lane LANE_W bits, modulo 2^LANE_W (wrap, no saturation, no cross-lane carry). Zero beats from the IMU (value==0 path) count toward remaining like any beat.
- in_valid in IDLE or DRAIN: beat dropped, acc unchanged, err_stray=1 next cycle for one cycle.
- cmd_valid outside IDLE: ignored (cmd_ready=0), command must be held by sender.
- Reset (rst=0 at edge), including mid-ACCUM/DRAIN: state IDLE, acc=0, remaining=0, latched row=0; in-flight row discarded.

## Timing
- Reset values: cmd_ready=1 (after first edge with rst=0 released), in_ready=0, out_valid=0, out_row=0, out_data=0, err_stray=0. While rst=0: cmd_ready=0.
- All outputs registered or decoded from state register only; no combinational path from in_*/cmd_* to any output.
- Command accepted at edge T → in_ready=1 from T+1.
- N beats (N≥1) on consecutive cycles from T+1 → out_valid=1 at T+N+1. cmd_nnz=0 → out_valid at T+1.
- Handshake at edge D → cmd_ready=1 at D+1; minimum row-to-row period = N+2 cycles.
- out_ready held low: out_valid/out_data/out_row unchanged indefinitely.

## Structure
- Shared package: LANE_W, LANES, data-width constant, FSM state encoding (IDLE/ACCUM/DRAIN) shared with the dispatcher side.
- One sub-module: lane_adder (LANE_W-bit wrap adder, instantiated LANES times via generate). Counter and FSM stay in the top.

## Test plan
- Reset: rst=0 3 cycles mid-ACCUM → all outputs 0, state IDLE; after release cmd_ready=1, prior partial row never emitted.
- Single row: cmd_row=5, cmd_nnz=3, beats lanes {1,2,3,4},{10,20,30,40},{0,0,0,0} → out_valid at T+4, out_data lanes {11,22,33,44}, out_row=5.
- Empty row: cmd_nnz=0, cmd_row=2 → out_valid at T+1, out_data=0, no in_ready asserted.
- Wrap: 2 beats lane0 = 0xFFFF_FFFF and 0x0000_0002, other lanes 0 → lane0=0x0000_0001, lane1=0 (no carry).
- Backpressure/gaps: nnz=2 with 3 idle cycles between beats, out_ready low 5 cycles → output stable throughout, single handshake, then cmd_ready=1 next cycle.
- Stray beat: in_valid=1 in IDLE with data 0xAA.. → err_stray pulse one cycle, following row sum unaffected.
